// File: rtl/alu_scheduler.sv
// Two-channel request scheduler in front of a shared multi-cycle ALU.
// One op in flight at a time; response is held until the consumer takes it.
module alu_scheduler #(
    parameter int            W              = 8,
    parameter int            N              = 4,
    parameter int            LAT            = 2,
    parameter int            LAT_MULT       = 3,
    parameter logic [N-1:0]  CMD_MULT_INC   = N'(9),
    parameter logic [N-1:0]  CMD_MULT_SHIFT = N'(10)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_mode,
    input  logic [1:0]       req_cin,
    input  logic [3:0]       req_inp_valid,
    input  logic [2*N-1:0]   req_cmd,
    input  logic [2*W-1:0]   req_opa,
    input  logic [2*W-1:0]   req_opb,
    output logic             alu_ce,
    output logic             alu_mode,
    output logic             alu_cin,
    output logic [1:0]       alu_inp_valid,
    output logic [N-1:0]     alu_cmd,
    output logic [W-1:0]     alu_opa,
    output logic [W-1:0]     alu_opb,
    input  logic [2*W-1:0]   alu_res,
    input  logic             alu_err,
    input  logic             alu_ov,
    input  logic             alu_cout,
    input  logic             alu_g,
    input  logic             alu_l,
    input  logic             alu_e,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*W-1:0]   rsp_res,
    output logic [5:0]       rsp_flags,
    output logic             busy,
    output logic [15:0]      op_count
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    localparam int LMAX = (LAT_MULT > LAT) ? LAT_MULT : LAT;
    localparam int CW   = (LMAX < 1) ? 1 : $clog2(LMAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last_grant;
    logic            op_id;
    logic [1:0]      grant;
    logic            sel;
    logic            sel_mode;
    logic            sel_cin;
    logic [1:0]      sel_iv;
    logic [N-1:0]    sel_cmd;
    logic [W-1:0]    sel_opa;
    logic [W-1:0]    sel_opb;
    logic            sel_mult;

    // Round-robin: on contention the channel that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE && rst) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign sel       = grant[1];
    assign sel_mode  = req_mode[sel];
    assign sel_cin   = req_cin[sel];
    assign sel_iv    = sel ? req_inp_valid[3:2] : req_inp_valid[1:0];
    assign sel_cmd   = sel ? req_cmd[2*N-1:N]   : req_cmd[N-1:0];
    assign sel_opa   = sel ? req_opa[2*W-1:W]   : req_opa[W-1:0];
    assign sel_opb   = sel ? req_opb[2*W-1:W]   : req_opb[W-1:0];
    assign sel_mult  = sel_mode && (sel_cmd == CMD_MULT_INC || sel_cmd == CMD_MULT_SHIFT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= 1'b1;
            op_id         <= 1'b0;
            alu_ce        <= 1'b0;
            alu_mode      <= 1'b0;
            alu_cin       <= 1'b0;
            alu_inp_valid <= 2'b00;
            alu_cmd       <= '0;
            alu_opa       <= '0;
            alu_opb       <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_res       <= '0;
            rsp_flags     <= 6'b0;
            op_count      <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_id         <= sel;
                        alu_mode      <= sel_mode;
                        alu_cin       <= sel_cin;
                        alu_inp_valid <= sel_iv;
                        alu_cmd       <= sel_cmd;
                        alu_opa       <= sel_opa;
                        alu_opb       <= sel_opb;
                        cnt           <= sel_mult ? CW'(LAT_MULT) : CW'(LAT);
                        alu_ce        <= 1'b1;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        rsp_res   <= alu_res;
                        rsp_flags <= {alu_err, alu_ov, alu_cout, alu_g, alu_l, alu_e};
                        rsp_id    <= op_id;
                        rsp_valid <= 1'b1;
                        alu_ce    <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    // Pointer moves only here, so idle gaps never change who wins next.
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        op_count   <= op_count + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    alu_ce    <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: a small behavioural ALU answers the scheduler,
// a vector table covers single ops, hand sequences cover arbitration, stalls, reset and wrap.
module tb_alu_scheduler;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [1:0]     req_mode;
    logic [1:0]     req_cin;
    logic [3:0]     req_inp_valid;
    logic [2*N-1:0] req_cmd;
    logic [2*W-1:0] req_opa;
    logic [2*W-1:0] req_opb;
    logic           alu_ce, alu_mode, alu_cin;
    logic [1:0]     alu_inp_valid;
    logic [N-1:0]   alu_cmd;
    logic [W-1:0]   alu_opa, alu_opb;
    logic [2*W-1:0] alu_res;
    logic           alu_err, alu_ov, alu_cout, alu_g, alu_l, alu_e;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [2*W-1:0] rsp_res;
    logic [5:0]     rsp_flags;
    logic           busy;
    logic [15:0]    op_count;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [15:0]    exp_cnt;

    typedef struct {
        logic        ch;
        logic        mode;
        logic        cin;
        logic [1:0]  iv;
        logic [3:0]  cmd;
        logic [7:0]  a;
        logic [7:0]  b;
        int          cyc;
        logic [15:0] res;
        logic [5:0]  flags;
    } vec_t;

    vec_t vecs[11];

    alu_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_cin(req_cin), .req_inp_valid(req_inp_valid), .req_cmd(req_cmd),
        .req_opa(req_opa), .req_opb(req_opb),
        .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin),
        .alu_inp_valid(alu_inp_valid), .alu_cmd(alu_cmd),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_res(alu_res),
        .alu_err(alu_err), .alu_ov(alu_ov), .alu_cout(alu_cout),
        .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .busy(busy), .op_count(op_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    // Behavioural ALU: mode 1 arithmetic, mode 0 logic; unknown ops and no operands flag err.
    always_comb begin
        alu_res  = '0;
        alu_err  = 1'b0;
        alu_ov   = 1'b0;
        alu_cout = 1'b0;
        alu_g    = 1'b0;
        alu_l    = 1'b0;
        alu_e    = 1'b0;
        if (alu_inp_valid == 2'b00) begin
            alu_err = 1'b1;
        end else if (alu_mode) begin
            case (alu_cmd)
                4'd0: begin
                    alu_res  = {8'b0, alu_opa} + {8'b0, alu_opb};
                    alu_cout = alu_res[W];
                end
                4'd1:    alu_res = {8'b0, alu_opa - alu_opb};
                4'd8: begin
                    alu_g = alu_opa > alu_opb;
                    alu_l = alu_opa < alu_opb;
                    alu_e = alu_opa == alu_opb;
                end
                4'd9:    alu_res = ({8'b0, alu_opa} + 16'd1) * ({8'b0, alu_opb} + 16'd1);
                4'd10:   alu_res = ({8'b0, alu_opa} << 1) * {8'b0, alu_opb};
                default: alu_err = 1'b1;
            endcase
        end else begin
            case (alu_cmd)
                4'd0:    alu_res = {8'b0, alu_opa & alu_opb};
                4'd1:    alu_res = {8'b0, alu_opa | alu_opb};
                default: alu_err = 1'b1;
            endcase
        end
    end

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic set_chan(input vec_t v);
        req_mode[v.ch] = v.mode;
        req_cin[v.ch]  = v.cin;
        if (v.ch) begin
            req_inp_valid[3:2] = v.iv;
            req_cmd[7:4]       = v.cmd;
            req_opa[15:8]      = v.a;
            req_opb[15:8]      = v.b;
        end else begin
            req_inp_valid[1:0] = v.iv;
            req_cmd[3:0]       = v.cmd;
            req_opa[7:0]       = v.a;
            req_opb[7:0]       = v.b;
        end
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (req_ready == 2'b00 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // One complete op; entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_op(input vec_t v);
        int k;
        int n;
        set_chan(v);
        req_valid[v.ch] = 1'b1;
        wait_ready(k);
        check("grant", 32'(req_ready), v.ch ? 32'h2 : 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("busy_after_accept", 32'(busy), 32'h1);
        check("alu_ce_busy", 32'(alu_ce), 32'h1);
        check("alu_ctrl", {22'b0, alu_mode, alu_cin, alu_inp_valid, alu_cmd},
              {22'b0, v.mode, v.cin, v.iv, v.cmd});
        check("alu_operands", {16'b0, alu_opa, alu_opb}, {16'b0, v.a, v.b});
        wait_rsp(n);
        check("rsp_latency", 32'(n), 32'(v.cyc));
        check("rsp_res", 32'(rsp_res), 32'(v.res));
        check("rsp_id", 32'(rsp_id), 32'(v.ch));
        check("rsp_flags", 32'(rsp_flags), 32'(v.flags));
        check("alu_ce_resp", 32'(alu_ce), 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check("op_count", 32'(op_count), 32'(exp_cnt));
        check("idle_after_rsp", {30'b0, busy, rsp_valid}, 32'h0);
    endtask

    initial begin
        int    k;
        int    n;
        int    seen;
        logic [1:0] exp_arb[3];
        logic [15:0] hold_res;
        vec_t  va;
        vec_t  vb;

        //                ch mode cin iv     cmd    a      b      cyc res     flags {err,ov,cout,g,l,e}
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'd0,  8'd200, 8'd100, 3, 16'd300, 6'b001000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd9,  8'd3,   8'd4,   4, 16'd20,  6'b000000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'd10, 8'd5,   8'd6,   4, 16'd60,  6'b000000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'b11, 4'd9,  8'd3,   8'd4,   3, 16'd0,   6'b100000};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'b11, 4'd1,  8'd50,  8'd20,  3, 16'd30,  6'b000000};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd8,  8'd7,   8'd7,   3, 16'd0,   6'b000001};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'd0,  8'd1,   8'd1,   3, 16'd0,   6'b100000};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd15, 8'd1,   8'd1,   3, 16'd0,   6'b100000};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b11, 4'd0,  8'hF0,  8'h3C,  3, 16'h0030, 6'b000000};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd0,  8'd255, 8'd255, 3, 16'd510, 6'b001000};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b10, 4'd8,  8'd9,   8'd4,   3, 16'd0,   6'b000100};
        exp_arb[0] = 2'b01;
        exp_arb[1] = 2'b10;
        exp_arb[2] = 2'b01;

        // reset with both channels already requesting
        rst           = 1'b0;
        rsp_ready     = 1'b0;
        req_valid     = 2'b11;
        req_mode      = 2'b00;
        req_cin       = 2'b00;
        req_inp_valid = 4'b0;
        req_cmd       = '0;
        req_opa       = '0;
        req_opb       = '0;
        exp_cnt       = 16'h0000;
        va = '{1'b0, 1'b1, 1'b0, 2'b11, 4'd0, 8'd1, 8'd2, 3, 16'd3, 6'b0};
        vb = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd0, 8'd3, 8'd4, 3, 16'd7, 6'b0};
        set_chan(va);
        set_chan(vb);
        #12;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_busy_ce_valid", {29'b0, busy, alu_ce, rsp_valid}, 32'h0);
        check("reset_op_count", 32'(op_count), 32'h0);
        check("reset_regs", {rsp_res, alu_opa, alu_opb}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // contention straight out of reset: ch0, ch1, ch0
        rsp_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            wait_ready(k);
            check("arb_grant", 32'(req_ready), 32'(exp_arb[g]));
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        rsp_ready = 1'b0;
        exp_cnt = 16'd3;
        check("arb_drained", 32'(busy), 32'h0);
        check("arb_op_count", 32'(op_count), 32'(exp_cnt));

        // vector table
        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // stalled response with ch1 waiting
        va = '{1'b0, 1'b1, 1'b0, 2'b11, 4'd0, 8'd10, 8'd20, 3, 16'd30, 6'b0};
        set_chan(va);
        set_chan(vb);
        req_valid = 2'b01;
        wait_ready(k);
        @(posedge clk); #1;
        req_valid = 2'b10;
        wait_rsp(n);
        check("stall_latency", 32'(n), 32'd3);
        hold_res = rsp_res;
        check("stall_first_res", 32'(hold_res), 32'd30);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_hold", {rsp_valid, rsp_id, rsp_flags, req_ready, alu_ce, 4'b0, rsp_res},
                  {1'b1, 1'b0, 6'b0, 2'b00, 1'b0, 4'b0, hold_res});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check("stall_op_count", 32'(op_count), 32'(exp_cnt));
        check("stall_no_same_cycle_accept", 32'(busy), 32'h0);
        check("stall_next_grant", 32'(req_ready), 32'h2);
        req_valid = 2'b00;

        // reset in the middle of a multiply
        set_chan(vecs[1]);
        req_valid = 2'b10;
        wait_ready(k);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        req_valid = 2'b01;
        rst = 1'b0;
        #1;
        check("midrst_ce_busy_valid", {29'b0, alu_ce, busy, rsp_valid}, 32'h0);
        check("midrst_op_count", 32'(op_count), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        #2 rst = 1'b1;
        req_valid = 2'b00;
        exp_cnt = 16'h0000;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) seen++;
        end
        check("midrst_no_response", 32'(seen), 32'h0);
        run_op(vecs[0]);

        // op_count wrap
        force dut.op_count = 16'hFFFD;
        #1 release dut.op_count;
        exp_cnt = 16'hFFFD;
        run_op(vecs[4]);
        run_op(vecs[1]);
        run_op(vecs[8]);
        check("wrap_zero", 32'(op_count), 32'h0);
        run_op(vecs[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
